// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - state_t        : scheduler FSM state encoding
//   - baud_t         : baud select codes understood by baud_rate_generator
//   - HDR_MARK       : upper nibble of every frame header byte
//   - BAUD_SEL_RESET : baud select driven out of reset
//   - hdr_byte()     : builds the header byte {HDR_MARK, id}
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_HDR      = 3'd2,
        ST_HDR_WAIT = 3'd3,
        ST_DAT      = 3'd4,
        ST_DAT_WAIT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        BAUD_0 = 2'b00,
        BAUD_1 = 2'b01,
        BAUD_2 = 2'b10,
        BAUD_3 = 2'b11
    } baud_t;

    localparam logic [3:0] HDR_MARK       = 4'hA;
    localparam logic [1:0] BAUD_SEL_RESET = BAUD_3;

    // Header byte: fixed marker nibble, requester id zero-extended to 4 bits.
    function automatic logic [7:0] hdr_byte(input logic [3:0] id4);
        return {HDR_MARK, id4};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req_i starting one past ptr_i and
// wrapping modulo N; the first set bit wins.
//   req_i    in  N    request vector
//   ptr_i    in  IDW  index of the most recently served requester
//   onehot_o out N    one-hot winner (all zero when no request)
//   idx_o    out IDW  binary index of the winner (0 when no request)
//   any_o    out 1    at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   onehot_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [IDW-1:0] cand;

    // Walk the scan order backwards so the last hit assigned is the one
    // closest to ptr_i+1, which gives priority without a break flag.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDW'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                onehot_o       = '0;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter and baud generator among N byte requesters.
// A round-robin winner's byte is latched, baud_sel is updated (with a settle
// delay if it changes) and a two-byte frame {HDR_MARK,id}, payload is sent.
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   req_valid    in   N      per-requester byte valid
//   req_data     in   8*N    requester i byte at [8i+7:8i]
//   req_ready    out  N      one-hot accept (combinational, IDLE only)
//   cfg_sel      in   2*N    requester i baud select at [2i+1:2i]
//   tx_start     out  1      one-cycle start pulse to the transmitter
//   tx_data      out  8      byte for the transmitter, stable until next start
//   tx_busy      in   1      transmitter busy
//   baud_sel     out  2      select to the baud generator
//   grant_id     out  IDW    id of the current/last granted requester
//   frame_active out  1      high from accept until payload busy falls
//   tx_err       out  1      one-cycle pulse when tx_busy never rises
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N          = 4,
    parameter int IDW        = $clog2(N),
    parameter int SETTLE_CYC = 4,
    parameter int BUSY_TO    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    input  logic [2*N-1:0]   cfg_sel,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic [1:0]       baud_sel,
    output logic [IDW-1:0]   grant_id,
    output logic             frame_active,
    output logic             tx_err
);

    localparam int CNT_MAX = (BUSY_TO > SETTLE_CYC) ? BUSY_TO : SETTLE_CYC;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYC - 1);
    localparam logic [CNTW-1:0] BUSY_LAST   = CNTW'(BUSY_TO - 1);

    // Per-requester views of the packed input buses.
    logic [7:0] req_byte [N];
    logic [1:0] req_sel  [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[8*gi +: 8];
        assign req_sel[gi]  = cfg_sel[2*gi +: 2];
    end

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_seen_q, busy_seen_d;
    logic [7:0]      data_q, data_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]      baud_sel_q, baud_sel_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            frame_active_q, frame_active_d;
    logic            tx_err_q, tx_err_d;

    logic [N-1:0]    pick_onehot;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            accept;
    logic [7:0]      win_byte;
    logic [1:0]      win_sel;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Accept only when the shared transmitter is really free.
    assign accept    = (state_q == ST_IDLE) && !tx_busy && pick_any;
    assign req_ready = accept ? pick_onehot : '0;
    assign win_byte  = req_byte[pick_idx];
    assign win_sel   = req_sel[pick_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            busy_seen_q    <= 1'b0;
            data_q         <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= IDW'(N - 1);
            baud_sel_q     <= BAUD_SEL_RESET;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            frame_active_q <= 1'b0;
            tx_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_seen_q    <= busy_seen_d;
            data_q         <= data_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
            baud_sel_q     <= baud_sel_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            frame_active_q <= frame_active_d;
            tx_err_q       <= tx_err_d;
        end
    end

    // HDR and DAT are the single cycles in which tx_start is high; the start
    // pulse and its byte are registered on the edge that enters them, so the
    // transmitter sees both stable for the whole cycle.
    // In the wait states cnt holds the number of cycles since the tx_start
    // cycle, so tx_err lands exactly BUSY_TO cycles after tx_start.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        busy_seen_d    = busy_seen_q;
        data_d         = data_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        baud_sel_d     = baud_sel_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        frame_active_d = frame_active_q;
        tx_err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d         = win_byte;
                    grant_id_d     = pick_idx;
                    frame_active_d = 1'b1;
                    if (win_sel == baud_sel_q) begin
                        state_d    = ST_HDR;
                        tx_start_d = 1'b1;
                        tx_data_d  = hdr_byte(4'(pick_idx));
                    end else begin
                        baud_sel_d = win_sel;
                        cnt_d      = '0;
                        state_d    = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d    = ST_HDR;
                    tx_start_d = 1'b1;
                    tx_data_d  = hdr_byte(4'(grant_id_q));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HDR: begin
                state_d     = ST_HDR_WAIT;
                cnt_d       = CNTW'(1);
                busy_seen_d = 1'b0;
            end

            ST_DAT: begin
                state_d     = ST_DAT_WAIT;
                cnt_d       = CNTW'(1);
                busy_seen_d = 1'b0;
            end

            ST_HDR_WAIT, ST_DAT_WAIT: begin
                if (!busy_seen_q) begin
                    // Phase A: waiting for the transmitter to pick up the byte.
                    if (tx_busy) begin
                        busy_seen_d = 1'b1;
                    end else if (cnt_q == BUSY_LAST) begin
                        tx_err_d       = 1'b1;
                        frame_active_d = 1'b0;
                        rr_ptr_d       = grant_id_q;
                        state_d        = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!tx_busy) begin
                    // Phase B: byte finished.
                    if (state_q == ST_HDR_WAIT) begin
                        state_d    = ST_DAT;
                        tx_start_d = 1'b1;
                        tx_data_d  = data_q;
                    end else begin
                        frame_active_d = 1'b0;
                        rr_ptr_d       = grant_id_q;
                        state_d        = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign baud_sel     = baud_sel_q;
    assign grant_id     = grant_id_q;
    assign frame_active = frame_active_q;
    assign tx_err       = tx_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed scenarios followed by a randomized run. A transaction-level model
// predicts, every cycle, what each output must be from the round-robin and
// latency rules; a transmitter model reacts to tx_start with tx_busy.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N          = 4;
    localparam int IDW        = 2;
    localparam int SETTLE_CYC = 4;
    localparam int BUSY_TO    = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   cfg_sel = '1;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy = 1'b0;
    logic [1:0]       baud_sel;
    logic [IDW-1:0]   grant_id;
    logic             frame_active;
    logic             tx_err;

    uart_tx_scheduler #(
        .N          (N),
        .IDW        (IDW),
        .SETTLE_CYC (SETTLE_CYC),
        .BUSY_TO    (BUSY_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cfg_sel      (cfg_sel),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .baud_sel     (baud_sel),
        .grant_id     (grant_id),
        .frame_active (frame_active),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    longint cyc  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requesters and transmitter stimulus ----------------
    logic [7:0]   rq [N][$];
    logic [1:0]   sel_cfg [N];
    logic [N-1:0] acc_seen = '0;
    int           pend_dly = 0;
    int           pend_len = 0;
    bit           busy_next = 1'b0;
    bit           stray_busy = 1'b0;
    bit           tx_dead = 1'b0;
    bit           rand_dead = 1'b0;

    // ---------------- transaction logs ----------------
    logic [7:0] sent_b [$];
    longint     sent_c [$];
    longint     acc_c  [$];
    longint     err_c  [$];

    // ---------------- behavioural model ----------------
    bit         m_idle, m_frame, m_inflight, m_seen, m_stage;
    int         m_ptr, m_gid;
    logic [1:0] m_baud;
    longint     m_start_at, m_err_at, m_tx_at;
    logic [7:0] m_start_byte, m_payload, m_last_data;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_frame = 0; m_inflight = 0; m_seen = 0; m_stage = 0;
        m_ptr = N - 1; m_gid = 0; m_baud = 2'b11;
        m_start_at = -1; m_err_at = -1; m_tx_at = -1;
        m_start_byte = 8'h00; m_payload = 8'h00; m_last_data = 8'h00;
    endtask

    function automatic logic [31:0] sb(input int i);
        return (i < sent_b.size()) ? 32'(sent_b[i]) : 32'hDEAD;
    endfunction
    function automatic longint sc(input int i);
        return (i < sent_c.size()) ? sent_c[i] : -1000;
    endfunction
    function automatic longint ac(input int i);
        return (i < acc_c.size()) ? acc_c[i] : -2000;
    endfunction
    function automatic longint ec(input int i);
        return (i < err_c.size()) ? err_c[i] : -3000;
    endfunction

    // Compare, log, advance the model and decide next-cycle tx_busy.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            model_reset();
            acc_seen  = '0;
            pend_dly  = 0;
            pend_len  = 0;
            busy_next = 1'b0;
        end else begin
            int w;
            logic [N-1:0] exp_ready;
            w = (m_idle && !tx_busy) ? pick(req_valid, m_ptr) : -1;
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;

            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("tx_start", 32'(tx_start), 32'(cyc == m_start_at));
            chk("tx_data", 32'(tx_data), 32'((cyc == m_start_at) ? m_start_byte : m_last_data));
            chk("tx_err", 32'(tx_err), 32'(cyc == m_err_at));
            chk("frame_active", 32'(frame_active), 32'(m_frame));
            chk("baud_sel", 32'(baud_sel), 32'(m_baud));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("start_while_busy", 32'(tx_start & tx_busy), 32'h0);

            if (tx_start) begin
                sent_b.push_back(tx_data);
                sent_c.push_back(cyc);
                $display("cyc %0d: tx_start byte=%02h baud_sel=%0d grant_id=%0d", cyc, tx_data, baud_sel, grant_id);
            end
            if (|(req_valid & req_ready)) begin
                acc_c.push_back(cyc);
                $display("cyc %0d: accept ready=%b", cyc, req_ready);
            end
            if (tx_err) begin
                err_c.push_back(cyc);
                $display("cyc %0d: tx_err grant_id=%0d", cyc, grant_id);
            end
            acc_seen = req_valid & req_ready;

            // Effects of the coming clock edge, in spec terms.
            if (cyc == m_start_at) m_last_data = m_start_byte;
            if (m_inflight && cyc > m_tx_at) begin
                if (!m_seen) begin
                    if (tx_busy) begin
                        m_seen = 1;
                    end else if (cyc - m_tx_at == BUSY_TO - 1) begin
                        m_err_at = cyc + 1;
                        m_frame = 0; m_idle = 1; m_ptr = m_gid; m_inflight = 0;
                    end
                end else if (!tx_busy) begin
                    m_inflight = 0;
                    if (!m_stage) begin
                        m_stage = 1;
                        m_start_at = cyc + 1;
                        m_start_byte = m_payload;
                    end else begin
                        m_frame = 0; m_idle = 1; m_ptr = m_gid;
                    end
                end
            end
            if (cyc == m_start_at) begin
                m_inflight = 1; m_tx_at = cyc; m_seen = 0;
            end
            if (w >= 0) begin
                logic [1:0] s;
                s = cfg_sel[2*w +: 2];
                m_gid = w; m_frame = 1; m_idle = 0; m_stage = 0;
                m_payload = req_data[8*w +: 8];
                m_start_byte = 8'hA0 + 8'(w);
                if (s == m_baud) begin
                    m_start_at = cyc + 1;
                end else begin
                    m_baud = s;
                    m_start_at = cyc + 1 + SETTLE_CYC;
                end
            end

            // Transmitter model.
            if (tx_start) begin
                if (tx_dead || (rand_dead && $urandom_range(0, 15) == 0)) begin
                    pend_dly = 0; pend_len = 0;
                end else begin
                    pend_dly = $urandom_range(0, 2);
                    pend_len = $urandom_range(2, 10);
                end
            end
            if (pend_dly > 0) begin
                busy_next = 1'b0; pend_dly--;
            end else if (pend_len > 0) begin
                busy_next = 1'b1; pend_len--;
            end else begin
                busy_next = 1'b0;
            end
            busy_next = busy_next | stray_busy;
        end
    end

    // Input driver: just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        acc_seen = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = (rq[i].size() > 0);
            req_data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            cfg_sel[2*i +: 2]   = sel_cfg[i];
        end
        tx_busy = busy_next;
    end

    task automatic clear_logs();
        sent_b.delete(); sent_c.delete(); acc_c.delete(); err_c.delete();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                rq[3].size() == 0 && !frame_active && req_valid == '0)
                quiet++;
            else
                quiet = 0;
        end
        total++;
        if (quiet < 3) begin
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1; tx_busy = 1'b0; busy_next = 1'b0; stray_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        for (int i = 0; i < N; i++) sel_cfg[i] = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_baud_sel", 32'(baud_sel), 32'h3);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_frame_active", 32'(frame_active), 32'h0);
        rst = 1'b0;

        // 1: single request, baud unchanged.
        clear_logs();
        rq[0].push_back(8'h69);
        wait_idle(400);
        chk("t1_count", 32'(sent_b.size()), 32'd2);
        chk("t1_hdr", sb(0), 32'hA0);
        chk("t1_payload", sb(1), 32'h69);
        chk("t1_latency", 32'(sc(0) - ac(0)), 32'd1);

        // 2: all four at once from reset pointer.
        do_reset();
        clear_logs();
        for (int i = 0; i < N; i++) rq[i].push_back(8'h10 + 8'(i));
        wait_idle(1000);
        chk("t2_count", 32'(sent_b.size()), 32'd8);
        for (int i = 0; i < N; i++) begin
            chk("t2_hdr", sb(2*i), 32'hA0 + 32'(i));
            chk("t2_payload", sb(2*i + 1), 32'h10 + 32'(i));
        end

        // 3: baud change with settle.
        clear_logs();
        sel_cfg[2] = 2'b01;
        rq[2].push_back(8'h5C);
        wait_idle(400);
        chk("t3_latency", 32'(sc(0) - ac(0)), 32'd5);
        chk("t3_hdr", sb(0), 32'hA2);
        chk("t3_payload", sb(1), 32'h5C);
        chk("t3_baud_hold", 32'(baud_sel), 32'h1);

        // 4: transmitter never goes busy.
        clear_logs();
        sel_cfg[3] = 2'b01; sel_cfg[0] = 2'b01;
        tx_dead = 1'b1;
        rq[3].push_back(8'h33);
        rq[0].push_back(8'h44);
        begin
            int n = 0;
            while (err_c.size() == 0 && n < 300) begin
                @(posedge clk);
                n++;
            end
            tx_dead = 1'b0;
        end
        wait_idle(600);
        chk("t4_err_dist", 32'(ec(0) - sc(0)), 32'd64);
        chk("t4_hdr_dropped", sb(0), 32'hA3);
        chk("t4_next_hdr", sb(1), 32'hA0);
        chk("t4_next_payload", sb(2), 32'h44);

        // 5: reset during payload wait.
        clear_logs();
        sel_cfg[1] = 2'b01;
        rq[1].push_back(8'h77);
        begin
            int n = 0;
            while (!(sent_b.size() >= 2 && tx_busy) && n < 300) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b1; tx_busy = 1'b0; busy_next = 1'b0;
        #1;
        chk("t5_tx_start", 32'(tx_start), 32'h0);
        chk("t5_tx_data", 32'(tx_data), 32'h0);
        chk("t5_baud_sel", 32'(baud_sel), 32'h3);
        chk("t5_grant_id", 32'(grant_id), 32'h0);
        chk("t5_frame_active", 32'(frame_active), 32'h0);
        chk("t5_tx_err", 32'(tx_err), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_logs();
        rq[1].push_back(8'h21);
        wait_idle(400);
        chk("t5_first_hdr", sb(0), 32'hA1);
        clear_logs();
        rq[0].push_back(8'h30);
        rq[1].push_back(8'h31);
        wait_idle(600);
        chk("t5_rr_hdr0", sb(0), 32'hA0);
        chk("t5_rr_hdr1", sb(2), 32'hA1);

        // 6: request while transmitter busy in IDLE.
        clear_logs();
        stray_busy = 1'b1;
        repeat (3) @(posedge clk);
        rq[3].push_back(8'h66);
        repeat (6) begin
            @(posedge clk);
            #2;
            chk("t6_ready_held", 32'(req_ready), 32'h0);
        end
        stray_busy = 1'b0;
        wait_idle(400);
        chk("t6_hdr", sb(0), 32'hA3);
        chk("t6_payload", sb(1), 32'h66);

        // Randomized traffic.
        rand_dead = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 5) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (rq[r].size() < 3) rq[r].push_back(8'($urandom));
            end
            if ($urandom_range(0, 49) == 0) sel_cfg[$urandom_range(0, N - 1)] = 2'($urandom);
        end
        wait_idle(3000);
        rand_dead = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
